// File: rtl/covuniq_pkg.sv
// Shared sizing and state encoding for the unique-tuple coverage monitor.
// The coverage bitmap is kept as 32 words of 8 bits each.
package covuniq_pkg;
    localparam int CMD_W_DEF  = 2;
    localparam int ADR_W_DEF  = 3;
    localparam int DATA_W_DEF = 3;
    localparam int NUM_WORDS  = 32;
    localparam int WORD_W     = 8;
    localparam int WADR_W     = 5;
    localparam int BIT_W      = 3;
    localparam int NUM_BINS   = 192;

    typedef enum logic {
        ST_CLEAR   = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;
endpackage

// File: rtl/uniq_cov_mon_if.sv
// Sampling bus between the observed master and the coverage monitor.
// The master modport drives the tuple and controls; the slave modport is the monitor.
interface uniq_cov_mon_if #(
    parameter int CMD_W  = 2,
    parameter int ADR_W  = 3,
    parameter int DATA_W = 3
);
    logic              en;
    logic              clr;
    logic [CMD_W-1:0]  cmd;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
    logic              new_hit;
    logic [7:0]        uniq_cnt;
    logic [15:0]       hit_cnt;
    logic              all_covered;
    logic              busy;

    modport master (
        output en, clr, cmd, adr, data,
        input  new_hit, uniq_cnt, hit_cnt, all_covered, busy
    );

    modport slave (
        input  en, clr, cmd, adr, data,
        output new_hit, uniq_cnt, hit_cnt, all_covered, busy
    );
endinterface

// File: rtl/uniq_bitmap.sv
// 32x8 coverage bitmap: one synchronous read port (old data on collision) and
// one write port whose word can be forced to zero for the clear sweep.
module uniq_bitmap
    import covuniq_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic              wclr,
    input  logic [WADR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WADR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [NUM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wclr ? '0 : wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/uniq_cov_mon.sv
// Unique-tuple coverage monitor: records {cmd,adr,data} tuples in a bitmap,
// counts distinct and total accepted tuples, and reports full coverage.
module uniq_cov_mon
    import covuniq_pkg::*;
#(
    parameter int CMD_W  = CMD_W_DEF,
    parameter int ADR_W  = ADR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    uniq_cov_mon_if.slave bus
);
    localparam int IW = CMD_W + ADR_W + DATA_W;

    state_t            state_q, state_d;
    logic [WADR_W-1:0] sweep_q, sweep_d;
    logic              acc;
    logic [IW-1:0]     idx_in;

    logic              vld_p0;
    logic [IW-1:0]     idx_p0;
    logic [WORD_W-1:0] rd_word_p0;

    logic              fwd_vld_p1;
    logic [WADR_W-1:0] fwd_adr_p1;
    logic [WORD_W-1:0] fwd_dat_p1;

    logic              proc;
    logic              bit_set;
    logic [WORD_W-1:0] cur_word, upd_word;
    logic              we, wclr;
    logic [WADR_W-1:0] waddr;

    logic              new_hit_q;
    logic [7:0]        uniq_q;
    logic [15:0]       hit_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign idx_in = {bus.cmd, bus.adr, bus.data};
    assign acc    = (state_q == ST_COLLECT) && bus.en && (bus.cmd != '0);

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (bus.clr) begin
            state_d = ST_CLEAR;
            sweep_d = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    sweep_d = sweep_q + 1'b1;
                    if (sweep_q == WADR_W'(NUM_WORDS - 1)) begin
                        state_d = ST_COLLECT;
                    end
                end
                default: state_d = ST_COLLECT;
            endcase
        end
    end

    // Stage p0 -> p1: resolve the hit against the bitmap, forwarding the
    // previous cycle's write because the synchronous read returned old data.
    assign proc     = vld_p0 && !bus.clr;
    assign cur_word = (fwd_vld_p1 && (fwd_adr_p1 == idx_p0[IW-1 -: WADR_W]))
                      ? fwd_dat_p1 : rd_word_p0;
    assign bit_set  = cur_word[idx_p0[BIT_W-1:0]];
    assign upd_word = cur_word | (WORD_W'(1) << idx_p0[BIT_W-1:0]);

    assign wclr  = (state_q == ST_CLEAR);
    assign we    = wclr || proc;
    assign waddr = wclr ? sweep_q : idx_p0[IW-1 -: WADR_W];

    uniq_bitmap u_bitmap (
        .clk   (clk),
        .we    (we),
        .wclr  (wclr),
        .waddr (waddr),
        .wdata (upd_word),
        .raddr (idx_in[IW-1 -: WADR_W]),
        .rdata (rd_word_p0)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            sweep_q    <= '0;
            vld_p0     <= 1'b0;
            fwd_vld_p1 <= 1'b0;
            new_hit_q  <= 1'b0;
            uniq_q     <= '0;
            hit_q      <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            vld_p0     <= acc && !bus.clr;
            fwd_vld_p1 <= proc;
            new_hit_q  <= proc && !bit_set;
            if (bus.clr) begin
                uniq_q <= '0;
                hit_q  <= '0;
            end else if (proc) begin
                uniq_q <= uniq_q + {7'd0, ~bit_set};
                hit_q  <= sat_inc16(hit_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        idx_p0     <= idx_in;
        fwd_adr_p1 <= waddr;
        fwd_dat_p1 <= upd_word;
    end

    assign bus.new_hit     = new_hit_q;
    assign bus.uniq_cnt    = uniq_q;
    assign bus.hit_cnt     = hit_q;
    assign bus.all_covered = (uniq_q == 8'(NUM_BINS));
    assign bus.busy        = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_uniq_cov_mon.sv
// Directed bench for uniq_cov_mon: reset sweep, forwarding, cmd=0 filtering,
// full coverage, clear behaviour, saturation and mid-stream reset.
module tb_uniq_cov_mon;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   nh_cnt   = 0;
    int   busy_len;

    always #5 clk = ~clk;

    uniq_cov_mon_if #(.CMD_W(2), .ADR_W(3), .DATA_W(3)) bus ();

    uniq_cov_mon #(.CMD_W(2), .ADR_W(3), .DATA_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.new_hit === 1'b1) nh_cnt++;
    endtask

    task automatic drive(input logic [1:0] c, input logic [2:0] a, input logic [2:0] d);
        bus.cmd  = c;
        bus.adr  = a;
        bus.data = d;
    endtask

    task automatic wait_idle(output int len);
        len = 0;
        while (bus.busy && len < 100) begin
            len++;
            tick();
        end
        check("busy_drop", bus.busy, 0);
    endtask

    task automatic sweep_all();
        for (int c = 1; c < 4; c++)
            for (int a = 0; a < 8; a++)
                for (int d = 0; d < 8; d++) begin
                    drive(2'(c), 3'(a), 3'(d));
                    tick();
                end
        drive(0, 0, 0);
        tick();
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.clr  = 1'b0;
        drive(0, 0, 0);
        repeat (3) tick();
        check("rst_busy", bus.busy, 1);
        check("rst_new_hit", bus.new_hit, 0);
        check("rst_uniq", bus.uniq_cnt, 0);
        check("rst_hit", bus.hit_cnt, 0);
        check("rst_all_cov", bus.all_covered, 0);

        rst_n = 1'b1;
        wait_idle(busy_len);
        check("busy_len", busy_len, 32);
        check("idle_uniq", bus.uniq_cnt, 0);
        check("idle_new_hit", bus.new_hit, 0);

        // cmd=0 never counts
        bus.en = 1'b1;
        nh_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            drive(0, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
            tick();
        end
        drive(0, 0, 0);
        tick();
        check("nop_uniq", bus.uniq_cnt, 0);
        check("nop_hit", bus.hit_cnt, 0);
        check("nop_new_hit_cnt", nh_cnt, 0);

        // same tuple on two consecutive cycles
        nh_cnt = 0;
        drive(2, 3, 5);
        tick();
        check("lat_new_hit_T", bus.new_hit, 0);
        tick();
        check("lat_new_hit_T1", bus.new_hit, 1);
        check("lat_uniq_T1", bus.uniq_cnt, 1);
        check("lat_hit_T1", bus.hit_cnt, 1);
        drive(0, 0, 0);
        tick();
        check("fwd_new_hit", bus.new_hit, 0);
        check("fwd_uniq", bus.uniq_cnt, 1);
        check("fwd_hit", bus.hit_cnt, 2);
        tick();
        check("fwd_pulses", nh_cnt, 1);

        // en=0 freezes everything
        bus.en = 1'b0;
        drive(1, 0, 0);
        repeat (5) tick();
        check("freeze_uniq", bus.uniq_cnt, 1);
        check("freeze_hit", bus.hit_cnt, 2);
        check("freeze_new_hit", bus.new_hit, 0);
        bus.en = 1'b1;
        drive(0, 0, 0);

        // full coverage and repeat sweep
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        wait_idle(busy_len);
        nh_cnt = 0;
        sweep_all();
        check("cov_pulses", nh_cnt, 192);
        check("cov_uniq", bus.uniq_cnt, 192);
        check("cov_hit", bus.hit_cnt, 192);
        check("cov_all", bus.all_covered, 1);
        nh_cnt = 0;
        sweep_all();
        check("rep_pulses", nh_cnt, 0);
        check("rep_uniq", bus.uniq_cnt, 192);
        check("rep_hit", bus.hit_cnt, 384);
        check("rep_all", bus.all_covered, 1);

        // clear from full coverage, then 10 unique hits
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("clr_all_cov", bus.all_covered, 0);
        check("clr_uniq0", bus.uniq_cnt, 0);
        wait_idle(busy_len);
        for (int i = 0; i < 10; i++) begin
            drive(1, 3'(i / 8), 3'(i % 8));
            tick();
        end
        drive(0, 0, 0);
        tick();
        check("ten_uniq", bus.uniq_cnt, 10);
        check("ten_hit", bus.hit_cnt, 10);

        // tuple accepted right before clr is discarded
        drive(3, 7, 7);
        tick();
        drive(0, 0, 0);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("kill_new_hit", bus.new_hit, 0);
        check("kill_uniq", bus.uniq_cnt, 0);
        check("kill_hit", bus.hit_cnt, 0);
        check("kill_busy", bus.busy, 1);
        drive(1, 2, 3);
        wait_idle(busy_len);
        check("busy_tuple_uniq", bus.uniq_cnt, 0);
        check("busy_tuple_hit", bus.hit_cnt, 0);
        tick();
        drive(0, 0, 0);
        tick();
        check("post_clr_new_hit", bus.new_hit, 1);
        check("post_clr_uniq", bus.uniq_cnt, 1);
        drive(3, 7, 7);
        tick();
        drive(0, 0, 0);
        tick();
        check("discarded_is_new", bus.new_hit, 1);
        check("discarded_uniq", bus.uniq_cnt, 2);

        // saturation
        drive(1, 0, 0);
        for (int i = 0; i < 70000; i++) tick();
        check("sat_hit", bus.hit_cnt, 65535);
        check("sat_uniq", bus.uniq_cnt, 3);

        // one-cycle reset mid-stream
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_hit", bus.hit_cnt, 0);
        check("mrst_uniq", bus.uniq_cnt, 0);
        check("mrst_busy", bus.busy, 1);
        check("mrst_new_hit", bus.new_hit, 0);
        wait_idle(busy_len);
        check("mrst_busy_len", busy_len, 32);
        tick();
        tick();
        check("mrst_new_hit_after", bus.new_hit, 1);
        check("mrst_uniq_after", bus.uniq_cnt, 1);
        check("mrst_hit_after", bus.hit_cnt, 1);
        tick();
        check("mrst_hit_after2", bus.hit_cnt, 2);
        check("mrst_new_hit_after2", bus.new_hit, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
